// File: rtl/joystick_axis_scanner.sv
// joystick_axis_scanner: sequences XADC DRP reads over N_CH aux channels,
// averages 2^AVG_LOG2 samples, applies hysteresis, emits press pulses.
// Ports: clk_100MHz/rst_n, sample_tick, DRP (drp_daddr/den/drdy/do),
// axis_data, dir_high/low, press_high/low, scan_done, timeout_err.
// Option: define JOY_AUTOREPEAT_EN to re-fire presses every REPEAT_SCANS.
module joystick_axis_scanner #(
  parameter int         N_CH         = 2,
  parameter logic [6:0] BASE_ADDR    = 7'h16,
  parameter int         AVG_LOG2     = 2,
  parameter int         TH_HIGH      = 3000,
  parameter int         TH_LOW       = 1000,
  parameter int         HYST         = 100,
  parameter int         TIMEOUT      = 255,
  parameter int         REPEAT_SCANS = 50
) (
  input  logic                 clk_100MHz,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  output logic [6:0]           drp_daddr,
  output logic                 drp_den,
  input  logic                 drp_drdy,
  input  logic [15:0]          drp_do,
  output logic [12*N_CH-1:0]   axis_data,
  output logic [N_CH-1:0]      dir_high,
  output logic [N_CH-1:0]      dir_low,
  output logic [N_CH-1:0]      press_high,
  output logic [N_CH-1:0]      press_low,
  output logic                 scan_done,
  output logic                 timeout_err
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW  = 12 + AVG_LOG2;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [11:0] HI_SET = 12'(TH_HIGH);
  localparam logic [11:0] HI_CLR = 12'(TH_HIGH - HYST);
  localparam logic [11:0] LO_SET = 12'(TH_LOW);
  localparam logic [11:0] LO_CLR = 12'(TH_LOW + HYST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_UPDATE,
    S_NEXT
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CHW-1:0]  ch;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [TW-1:0]   timer;
  logic [11:0]     avg;
  logic [N_CH-1:0] hi_q;
  logic [N_CH-1:0] lo_q;
  logic [N_CH-1:0] rep_hi;
  logic [N_CH-1:0] rep_lo;
  logic            last_smp;
  logic            last_ch;
  logic            tmo;
  logic            unused_bits;

  assign last_smp = (cnt == CW'((1 << AVG_LOG2) - 1));
  assign last_ch  = (ch == CHW'(N_CH - 1));
  assign tmo      = !drp_drdy && (timer == TW'(TIMEOUT - 1));
  assign avg      = 12'(acc >> AVG_LOG2);

  // den/daddr decode straight from state so async reset drops them at once
  assign drp_den   = (state_q == S_REQ);
  assign drp_daddr = drp_den ? (BASE_ADDR + 7'(ch)) : 7'd0;

  assign unused_bits = ^drp_do[3:0];

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (sample_tick) state_d = S_REQ;
      S_REQ:    state_d = S_WAIT;
      S_WAIT: begin
        if (drp_drdy)
          state_d = last_smp ? S_UPDATE : S_REQ;
        else if (tmo)
          state_d = S_NEXT;
      end
      S_UPDATE: state_d = S_NEXT;
      S_NEXT:   state_d = last_ch ? S_IDLE : S_REQ;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      ch          <= '0;
      cnt         <= '0;
      acc         <= '0;
      timer       <= '0;
      axis_data   <= '0;
      dir_high    <= '0;
      dir_low     <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sample_tick) begin
            ch  <= '0;
            cnt <= '0;
            acc <= '0;
          end
        end
        S_REQ: timer <= '0;
        S_WAIT: begin
          if (drp_drdy) begin
            acc <= acc + AW'(drp_do[15:4]);
            if (!last_smp) cnt <= cnt + 1'b1;
          end else if (tmo) begin
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_UPDATE: begin
          axis_data[12*ch +: 12] <= avg;
          if (avg > HI_SET)      dir_high[ch] <= 1'b1;
          else if (avg < HI_CLR) dir_high[ch] <= 1'b0;
          if (avg < LO_SET)      dir_low[ch] <= 1'b1;
          else if (avg > LO_CLR) dir_low[ch] <= 1'b0;
        end
        S_NEXT: begin
          if (last_ch) begin
            scan_done <= 1'b1;
          end else begin
            ch  <= ch + 1'b1;
            cnt <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      lo_q       <= '0;
      press_high <= '0;
      press_low  <= '0;
    end else begin
      hi_q       <= dir_high;
      lo_q       <= dir_low;
      press_high <= (dir_high & ~hi_q) | rep_hi;
      press_low  <= (dir_low & ~lo_q) | rep_lo;
    end
  end

`ifdef JOY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);

  logic [RW-1:0] rc_hi [N_CH];
  logic [RW-1:0] rc_lo [N_CH];
  logic          scan_end;

  assign scan_end = (state_q == S_NEXT) && last_ch;

  // counter runs 1..REPEAT_SCANS; the assert scan itself loads 1
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        rc_hi[k] <= '0;
        rc_lo[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (!dir_high[k])
          rc_hi[k] <= '0;
        else if (scan_end)
          rc_hi[k] <= (rc_hi[k] == RW'(REPEAT_SCANS)) ?
                      RW'(1) : rc_hi[k] + 1'b1;
        if (!dir_low[k])
          rc_lo[k] <= '0;
        else if (scan_end)
          rc_lo[k] <= (rc_lo[k] == RW'(REPEAT_SCANS)) ?
                      RW'(1) : rc_lo[k] + 1'b1;
      end
    end
  end

  always_comb begin
    rep_hi = '0;
    rep_lo = '0;
    for (int k = 0; k < N_CH; k++) begin
      rep_hi[k] = scan_end && dir_high[k] &&
                  (rc_hi[k] == RW'(REPEAT_SCANS));
      rep_lo[k] = scan_end && dir_low[k] &&
                  (rc_lo[k] == RW'(REPEAT_SCANS));
    end
  end
`else
  logic unused_rep;

  assign unused_rep = (REPEAT_SCANS > 0);
  assign rep_hi     = '0;
  assign rep_lo     = '0;
`endif

endmodule

// File: tb/tb_joystick_axis_scanner.sv
// tb_joystick_axis_scanner: scoreboard bench with a DRP responder model.
// Expected scan results are queued by stimulus and checked at scan_done.
module tb_joystick_axis_scanner;

  logic        clk_100MHz = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [23:0] axis_data;
  logic [1:0]  dir_high;
  logic [1:0]  dir_low;
  logic [1:0]  press_high;
  logic [1:0]  press_low;
  logic        scan_done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] axis;
    logic [1:0]  dh;
    logic [1:0]  dl;
    int          ph;
    int          pl;
    logic        te;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] smp_q[$];
  logic [6:0]  addr_q[$];
  logic [6:0]  mute_addr = 7'h7f;
  bit          mute_all  = 1'b0;
  bit          late_req  = 1'b0;

  always #5 clk_100MHz = ~clk_100MHz;

  joystick_axis_scanner dut (
    .clk_100MHz  (clk_100MHz),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .drp_daddr   (drp_daddr),
    .drp_den     (drp_den),
    .drp_drdy    (drp_drdy),
    .drp_do      (drp_do),
    .axis_data   (axis_data),
    .dir_high    (dir_high),
    .dir_low     (dir_low),
    .press_high  (press_high),
    .press_low   (press_low),
    .scan_done   (scan_done),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " daddr"}, 32'(drp_daddr), 32'd0);
    chk({tag, " den"}, 32'(drp_den), 32'd0);
    chk({tag, " axis"}, 32'(axis_data), 32'd0);
    chk({tag, " dir_high"}, 32'(dir_high), 32'd0);
    chk({tag, " dir_low"}, 32'(dir_low), 32'd0);
    chk({tag, " press_high"}, 32'(press_high), 32'd0);
    chk({tag, " press_low"}, 32'(press_low), 32'd0);
    chk({tag, " scan_done"}, 32'(scan_done), 32'd0);
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // DRP responder: one drdy a cycle after each den, samples in order
  initial begin
    logic [6:0]  a;
    logic [15:0] d;
    drp_drdy = 1'b0;
    drp_do   = 16'h0;
    forever begin
      @(negedge clk_100MHz);
      if (late_req) begin
        late_req = 1'b0;
        drp_drdy = 1'b1;
        drp_do   = 16'hFFF0;
        @(negedge clk_100MHz);
        drp_drdy = 1'b0;
      end else if (drp_den) begin
        a = drp_daddr;
        if (addr_q.size() == 0) begin
          chk("unexpected den", 32'(a), 32'h7f);
        end else begin
          chk("drp_daddr", 32'(a), 32'(addr_q.pop_front()));
        end
        if (!mute_all && a != mute_addr) begin
          if (smp_q.size() == 0) begin
            chk("sample underrun", 32'(a), 32'h7e);
            d = 16'h0;
          end else begin
            d = smp_q.pop_front();
          end
          @(posedge clk_100MHz);
          #1;
          drp_drdy = 1'b1;
          drp_do   = d;
          @(posedge clk_100MHz);
          #1;
          drp_drdy = 1'b0;
          drp_do   = 16'h000F;
        end
      end
    end
  end

  // monitor: count press pulses per scan, compare at scan_done
  initial begin
    int   ph;
    int   pl;
    exp_t e;
    ph = 0;
    pl = 0;
    forever begin
      @(negedge clk_100MHz);
      if (rst_n !== 1'b1) begin
        ph = 0;
        pl = 0;
      end else begin
        ph += $countones(press_high);
        pl += $countones(press_low);
        if (scan_done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected scan_done", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("axis_data", 32'(axis_data), 32'(e.axis));
            chk("dir_high", 32'(dir_high), 32'(e.dh));
            chk("dir_low", 32'(dir_low), 32'(e.dl));
            chk("press_high count", ph, e.ph);
            chk("press_low count", pl, e.pl);
            chk("timeout_err", 32'(timeout_err), 32'(e.te));
            chk("dir exclusive", 32'(dir_high & dir_low), 32'd0);
          end
          ph = 0;
          pl = 0;
        end
      end
    end
  end

  task automatic scan(input int a0, a1, a2, a3,
                      input int b0, b1, b2, b3,
                      input logic [11:0] ax0, ax1,
                      input logic [1:0] dh, dl,
                      input int ph, pl,
                      input logic te, input bit mute0,
                      input bit hold);
    int   v[8];
    exp_t e;
    bit   got;
    v = '{a0, a1, a2, a3, b0, b1, b2, b3};
    mute_addr = mute0 ? 7'h16 : 7'h7f;
    for (int k = 0; k < 8; k++)
      if (!(mute0 && k < 4))
        smp_q.push_back(16'((v[k] << 4) | 9));
    if (mute0) addr_q.push_back(7'h16);
    else for (int k = 0; k < 4; k++) addr_q.push_back(7'h16);
    for (int k = 0; k < 4; k++) addr_q.push_back(7'h17);
    e.axis = {ax1, ax0};
    e.dh   = dh;
    e.dl   = dl;
    e.ph   = ph;
    e.pl   = pl;
    e.te   = te;
    sb_q.push_back(e);
    @(negedge clk_100MHz);
    sample_tick = 1'b1;
    if (!hold) begin
      @(negedge clk_100MHz);
      sample_tick = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_100MHz);
      if (scan_done) begin
        got = 1'b1;
        break;
      end
    end
    sample_tick = 1'b0;
    chk("scan_done seen", 32'(got), 32'd1);
    repeat (4) @(negedge clk_100MHz);
    mute_addr = 7'h7f;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    chk_zero("in reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    chk_zero("idle");

    scan(2048, 2048, 2048, 2048, 2048, 2048, 2048, 2048,
         12'd2048, 12'd2048, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    scan(3001, 3001, 3001, 3001, 2048, 2048, 2048, 2048,
         12'd3001, 12'd2048, 2'b01, 2'b00, 1, 0, 1'b0, 1'b0, 1'b0);
    scan(2950, 2950, 2950, 2950, 2048, 2048, 2048, 2048,
         12'd2950, 12'd2048, 2'b01, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    scan(2900, 2900, 2900, 2900, 2048, 2048, 2048, 2048,
         12'd2900, 12'd2048, 2'b01, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    scan(2899, 2899, 2899, 2899, 2048, 2048, 2048, 2048,
         12'd2899, 12'd2048, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    scan(3000, 3000, 3000, 3000, 2048, 2048, 2048, 2048,
         12'd3000, 12'd2048, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    scan(2048, 2048, 2048, 2048, 1000, 1000, 1000, 999,
         12'd2048, 12'd999, 2'b00, 2'b10, 0, 1, 1'b0, 1'b0, 1'b0);
    scan(2048, 2048, 2048, 2048, 1100, 1100, 1100, 1100,
         12'd2048, 12'd1100, 2'b00, 2'b10, 0, 0, 1'b0, 1'b0, 1'b0);
    scan(2048, 2048, 2048, 2048, 1101, 1101, 1101, 1101,
         12'd2048, 12'd1101, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    scan(2048, 2048, 2048, 2048, 1000, 1000, 1000, 1000,
         12'd2048, 12'd1000, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    scan(500, 500, 500, 500, 4095, 4095, 4095, 4095,
         12'd500, 12'd4095, 2'b10, 2'b01, 1, 1, 1'b0, 1'b0, 1'b0);
    scan(4000, 4000, 4000, 4000, 0, 0, 0, 0,
         12'd4000, 12'd0, 2'b01, 2'b10, 1, 1, 1'b0, 1'b0, 1'b0);
    scan(2048, 2049, 2049, 2049, 2048, 2048, 2048, 2048,
         12'd2048, 12'd2048, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    scan(0, 0, 0, 0, 1500, 1500, 1500, 1500,
         12'd2048, 12'd1500, 2'b00, 2'b00, 0, 0, 1'b1, 1'b1, 1'b0);
    scan(3500, 3500, 3500, 3500, 2048, 2048, 2048, 2048,
         12'd3500, 12'd2048, 2'b01, 2'b00, 1, 0, 1'b1, 1'b0, 1'b1);

    mute_all = 1'b1;
    addr_q.push_back(7'h16);
    @(negedge clk_100MHz);
    sample_tick = 1'b1;
    @(negedge clk_100MHz);
    sample_tick = 1'b0;
    chk("den before reset", 32'(drp_den), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("reset mid read");
    @(negedge clk_100MHz);
    rst_n    = 1'b1;
    mute_all = 1'b0;
    late_req = 1'b1;
    repeat (20) @(negedge clk_100MHz);
    chk_zero("after late drdy");

    scan(3001, 3001, 3001, 3001, 500, 500, 500, 500,
         12'd3001, 12'd500, 2'b01, 2'b10, 1, 1, 1'b0, 1'b0, 1'b0);

    chk("scoreboard left", 32'(sb_q.size()), 32'd0);
    chk("samples left", 32'(smp_q.size()), 32'd0);
    chk("addresses left", 32'(addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/joystick_axis_scanner.md
Name: joystick_axis_scanner

Overview:
- Parametrised multi-channel analog joystick front end. Sequences XADC DRP reads across N_CH consecutive auxiliary channels.
- Averages 2^AVG_LOG2 conversions per channel, then converts each average into direction levels using hysteresis.
- Emits one-cycle press pulses when a direction asserts.
- Sits between the XADC wizard's DRP port and the game/menu control logic; replaces the fixed two-axis threshold decoder.

Parameters:
- N_CH, 2, number of axes scanned; channel k uses DRP address BASE_ADDR+k.
- BASE_ADDR, 7'h16, DRP address of channel 0 (VAUX6).
- AVG_LOG2, 2, log2 of samples averaged per channel per scan; 0 disables averaging.
- TH_HIGH, 3000, 12-bit level above which the high direction asserts.
- TH_LOW, 1000, 12-bit level below which the low direction asserts.
- HYST, 100, hysteresis band; TH_LOW+HYST < TH_HIGH-HYST is required.
- TIMEOUT, 255, cycles to wait for drdy before abandoning a channel.
- REPEAT_SCANS, 50, auto-repeat period in completed scans (used only with JOY_AUTOREPEAT_EN).

Ports:
- clk_100MHz  in  1  system clock; also the DRP dclk.
- rst_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle scan start request.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, one-cycle pulse.
- drp_drdy  in  1  DRP read data valid.
- drp_do  in  16  DRP read data; the result is in [15:4].
- axis_data  out  12*N_CH  averaged value per channel; channel k occupies [12k+11:12k].
- dir_high  out  N_CH  level; axis past the high threshold (up/right).
- dir_low  out  N_CH  level; axis past the low threshold (down/left).
- press_high  out  N_CH  one-cycle pulse when dir_high rises.
- press_low  out  N_CH  one-cycle pulse when dir_low rises.
- scan_done  out  1  one-cycle pulse when the last channel's scan completes.
- timeout_err  out  1  sticky flag; set when a DRP read times out.

Behaviour:
- Reset (async): every output is 0, including drp_daddr. FSM goes to IDLE. Accumulators, channel index and sample counter clear. Reset asserted mid-read deasserts drp_den immediately, and any late drp_drdy after release is ignored.
- IDLE:
  - sample_tick=1 → REQ; ch=0, cnt=0, acc=0.
  - sample_tick while not in IDLE is ignored, not queued.
- REQ: for exactly one cycle, drp_den=1 and drp_daddr=BASE_ADDR+ch. → WAIT with the timer cleared.
- WAIT:
  - drp_den=0.
  - When drp_drdy=1: acc += drp_do[15:4]. acc width is 12+AVG_LOG2, so it never overflows. Then:
    - if cnt < 2^AVG_LOG2-1: cnt++ and → REQ;
    - otherwise → UPDATE.
  - drp_drdy seen in any other state is ignored.
  - Timer reaches TIMEOUT with no drdy: set timeout_err, discard acc, leave this channel's axis_data and dir bits unchanged, → NEXT.
- UPDATE (one cycle):
  - avg = acc >> AVG_LOG2 (truncating); written to axis_data[ch].
  - Hysteresis on dir_high: set if avg > TH_HIGH; clear if avg < TH_HIGH-HYST; otherwise hold.
  - Hysteresis on dir_low: set if avg < TH_LOW; clear if avg > TH_LOW+HYST; otherwise hold.
  - press_high/press_low pulse on the cycle after the matching dir bit rises from 0 to 1.
  - → NEXT.
- NEXT:
  - if ch == N_CH-1: scan_done pulses for 1 cycle, → IDLE;
  - otherwise ch++, cnt=0, acc=0, → REQ.
- Latency: from sample_tick to scan_done is N_CH*2^AVG_LOG2 reads, each taking 2 cycles plus the drdy wait, plus 2 cycles per channel.
- Boundaries:
  - avg exactly equal to TH_HIGH or TH_LOW does not assert.
  - avg exactly at TH_HIGH-HYST does not clear.
  - dir_high and dir_low for the same channel are never both 1.
- timeout_err clears only on reset.

Optional Feature:
- Macro: JOY_AUTOREPEAT_EN.
- Defined: each channel gets a scan counter. While a dir bit stays 1, the matching press pulse re-fires at the scan_done of every REPEAT_SCANS-th completed scan after assertion. The counter resets when the dir bit falls.
- Undefined: press pulses fire only on the 0→1 transition. REPEAT_SCANS is unused.

Test Plan:
- Reset, then idle → all outputs 0. Tick with N_CH=2, AVG_LOG2=2, DRP model returning 2048<<4 → 8 den pulses at addresses 16,16,16,16,17,17,17,17; axis_data both 2048; scan_done 1 pulse; no dir bits.
- Channel 0 returns 3001<<4 → dir_high[0]=1 with one press_high[0] pulse. Next scans at 2950 → dir stays 1, no pulse. Then 2899 → dir_high[0]=0.
- Averaging: channel 1 samples 1000, 1000, 1000, 999 → avg 999, dir_low[1]=1. Samples all 1000 → avg 1000, no assert.
- DRP model never returns drdy for channel 0 → timeout_err=1 after 255 wait cycles; channel 1 is still read and updated; axis_data[0] unchanged; scan_done pulses.
- sample_tick held high throughout a scan → exactly one scan until IDLE. Reset asserted while in WAIT → drp_den=0 immediately and all outputs 0.
- With JOY_AUTOREPEAT_EN and REPEAT_SCANS=3, hold 3500 on channel 0 for 10 scans → press_high[0] on scans 1, 4, 7 and 10.
